// File: rtl/dma_xfer_ctrl.sv
// DMA channel controller driving a 10-bit up/down address counter.
// Optional DMA_AUTOINIT_EN: restart the same block after each completion.
module dma_xfer_ctrl #(
  parameter int AW = 10,
  parameter int LW = 10
) (
  input  logic          clk,
  input  logic          MR,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] xfer_len,
  input  logic          dir_up,
  input  logic          dreq,
  input  logic [AW-1:0] count,
  input  logic          carry,
  output logic [AW-1:0] cnt_data,
  output logic          cnt_load,
  output logic          cnt_en,
  output logic          cnt_dir,
  output logic          dack,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_XFER,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [AW-1:0] base_q;
  logic          dir_q;
  logic          err_q;
  logic [LW-1:0] rem_q;
  logic          last_word;
  logic          restart;

  assign last_word = (rem_q == LW'(1));

`ifdef DMA_AUTOINIT_EN
  logic [LW-1:0] len_q;
  // a zero-length block never re-arms, it falls back to IDLE
  assign restart = (len_q != '0);
`else
  assign restart = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (MR) state_q <= S_IDLE;
    else    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start)
          state_d = (xfer_len == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (dreq) state_d = S_XFER;
      end
      S_XFER: begin
        if (carry)          state_d = S_IDLE;
        else if (last_word) state_d = S_DONE;
        else if (dreq)      state_d = S_XFER;
        else                state_d = S_WAIT;
      end
      S_DONE: state_d = restart ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    dack     = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_LOAD: cnt_load = 1'b1;
      S_XFER: begin
        cnt_en = 1'b1;
        dack   = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (MR) begin
      base_q <= '0;
      dir_q  <= 1'b0;
      err_q  <= 1'b0;
      rem_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            dir_q  <= dir_up;
            err_q  <= 1'b0;
            rem_q  <= xfer_len;
          end
        end
        S_XFER: begin
          // a wrap aborts the word, so the count is not consumed
          if (carry) err_q <= 1'b1;
          else       rem_q <= rem_q - LW'(1);
        end
`ifdef DMA_AUTOINIT_EN
        S_DONE: begin
          if (restart) rem_q <= len_q;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef DMA_AUTOINIT_EN
  always_ff @(posedge clk) begin
    if (MR)
      len_q <= '0;
    else if (state_q == S_IDLE && start)
      len_q <= xfer_len;
  end
`endif

  assign cnt_data  = base_q;
  assign cnt_dir   = dir_q;
  assign err       = err_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Bench for dma_xfer_ctrl paired with a behavioural 10-bit up/down counter.
// Expected addresses are queued at start and popped on every dack.
module tb_dma_xfer_ctrl;

  logic       clk = 1'b0;
  logic       MR, start, dir_up, dreq;
  logic [9:0] base_addr, xfer_len;
  logic [9:0] count;
  logic       carry;
  logic [9:0] cnt_data, remaining;
  logic       cnt_load, cnt_en, cnt_dir;
  logic       dack, busy, done, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dack_n, done_n, load_n;
  int first_dack_cyc, last_dack_cyc, done_cyc;
  int done_hist[$];
  logic prev_dreq;
  logic [9:0] exp_q[$];

  always #10 clk = ~clk;

  dma_xfer_ctrl #(.AW(10), .LW(10)) dut (
    .clk(clk), .MR(MR), .start(start),
    .base_addr(base_addr), .xfer_len(xfer_len),
    .dir_up(dir_up), .dreq(dreq),
    .count(count), .carry(carry),
    .cnt_data(cnt_data), .cnt_load(cnt_load),
    .cnt_en(cnt_en), .cnt_dir(cnt_dir),
    .dack(dack), .busy(busy), .done(done),
    .err(err), .remaining(remaining)
  );

  // counter_10bit model
  always_ff @(posedge clk) begin
    if (MR)            count <= '0;
    else if (cnt_load) count <= cnt_data;
    else if (cnt_en)   count <= cnt_dir ? count + 10'd1 : count - 10'd1;
  end
  assign carry = cnt_en &&
    (cnt_dir ? (count == 10'h3FF) : (count == 10'h000));

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: address scoreboard and event stamps
  always @(negedge clk) begin
    if (dack === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dack_unexpected count=%0d none_expected", count);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (count !== e) begin
          errors++;
          $display("FAIL dack_addr got=%0d exp=%0d", count, e);
        end
      end
      checks++;
      if (prev_dreq !== 1'b1) begin
        errors++;
        $display("FAIL dack_without_dreq got=%b exp=1", prev_dreq);
      end
      if (dack_n == 0) first_dack_cyc = cyc;
      last_dack_cyc = cyc;
      dack_n++;
    end
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
      done_hist.push_back(cyc);
    end
    if (cnt_load === 1'b1) load_n++;
    prev_dreq = dreq;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    dack_n = 0; done_n = 0; load_n = 0;
    first_dack_cyc = 0; last_dack_cyc = 0; done_cyc = 0;
    done_hist.delete();
  endtask

  task automatic test_reset();
    MR = 1'b1; start = 0; dreq = 0;
    base_addr = '0; xfer_len = '0; dir_up = 0;
    tick(); tick();
    MR = 1'b0;
    tick();
    checks++;
    if ({cnt_data, cnt_load, cnt_en, cnt_dir, dack,
         busy, done, err, remaining} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
        {cnt_data, cnt_load, cnt_en, cnt_dir, dack,
         busy, done, err, remaining});
    end
  endtask

  task automatic test_basic_up();
    int s, n;
    clear_stats();
    base_addr = 10'd100; xfer_len = 10'd3; dir_up = 1;
    dreq = 1; start = 1;
    exp_q.push_back(10'd100);
    exp_q.push_back(10'd101);
    exp_q.push_back(10'd102);
    s = cyc;
    tick();
    start = 0;
    checks++;
    if (cnt_load !== 1 || cnt_data !== 10'd100 || cnt_dir !== 1) begin
      errors++;
      $display("FAIL basic_load got=%b/%0d/%b exp=1/100/1",
        cnt_load, cnt_data, cnt_dir);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_timeout got=%b exp=1", done);
    end
    checks++;
    if (first_dack_cyc - s != 3) begin
      errors++;
      $display("FAIL basic_first_dack_lat got=%0d exp=3",
        first_dack_cyc - s);
    end
    checks++;
    if (cyc - last_dack_cyc != 1) begin
      errors++;
      $display("FAIL basic_done_lat got=%0d exp=1",
        cyc - last_dack_cyc);
    end
    checks++;
    if (dack_n != 3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_dacks got=%0d/%b exp=3/1", dack_n, busy);
    end
    tick();
    checks++;
    if (busy !== 0 || remaining !== 0 || done !== 0 || err !== 0) begin
      errors++;
      $display("FAIL basic_end got=%b/%0d/%b/%b exp=0/0/0/0",
        busy, remaining, done, err);
    end
  endtask

  task automatic test_toggle_down();
    int n;
    clear_stats();
    base_addr = 10'd50; xfer_len = 10'd4; dir_up = 0;
    dreq = 1; start = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back(10'(50 - i));
    tick();
    start = 0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      dreq = ~dreq;
      tick(); n++;
    end
    dreq = 0;
    checks++;
    if (done !== 1'b1 || dack_n != 4) begin
      errors++;
      $display("FAIL toggle_done got=%b/%0d exp=1/4", done, dack_n);
    end
    tick();
    checks++;
    if (exp_q.size() != 0 || busy !== 0 || remaining !== 0) begin
      errors++;
      $display("FAIL toggle_end got=%0d/%b/%0d exp=0/0/0",
        exp_q.size(), busy, remaining);
    end
  endtask

  task automatic test_wrap_err();
    int n;
    clear_stats();
    base_addr = 10'd1022; xfer_len = 10'd5; dir_up = 1;
    dreq = 1; start = 1;
    exp_q.push_back(10'd1022);
    exp_q.push_back(10'd1023);
    tick();
    start = 0;
    tick();
    n = 0;
    while (busy === 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (busy !== 0 || err !== 1 || done_n != 0) begin
      errors++;
      $display("FAIL wrap_abort got=%b/%b/%0d exp=0/1/0",
        busy, err, done_n);
    end
    checks++;
    if (dack_n != 2 || remaining !== 10'd4) begin
      errors++;
      $display("FAIL wrap_counts got=%0d/%0d exp=2/4",
        dack_n, remaining);
    end
    tick();
    checks++;
    if (err !== 1) begin
      errors++;
      $display("FAIL wrap_sticky got=%b exp=1", err);
    end
    clear_stats();
    base_addr = 10'd10; xfer_len = 10'd1; dir_up = 1;
    start = 1;
    exp_q.push_back(10'd10);
    tick();
    start = 0;
    checks++;
    if (err !== 0) begin
      errors++;
      $display("FAIL wrap_err_clear got=%b exp=0", err);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (done_n != 1 || dack_n != 1 || err !== 0) begin
      errors++;
      $display("FAIL wrap_next_xfer got=%0d/%0d/%b exp=1/1/0",
        done_n, dack_n, err);
    end
  endtask

  task automatic test_zero_len();
    clear_stats();
    base_addr = 10'd7; xfer_len = 10'd0; dir_up = 1;
    dreq = 1; start = 1;
    tick();
    start = 0;
    checks++;
    if (done !== 1 || busy !== 1 || cnt_load !== 0) begin
      errors++;
      $display("FAIL zero_done got=%b/%b/%b exp=1/1/0",
        done, busy, cnt_load);
    end
    tick(); tick();
    checks++;
    if (busy !== 0 || dack_n != 0 || load_n != 0 || done_n != 1) begin
      errors++;
      $display("FAIL zero_end got=%b/%0d/%0d/%0d exp=0/0/0/1",
        busy, dack_n, load_n, done_n);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    clear_stats();
    base_addr = 10'd200; xfer_len = 10'd3; dir_up = 1;
    dreq = 1; start = 1;
    for (int i = 0; i < 3; i++) exp_q.push_back(10'(200 + i));
    tick();
    start = 0;
    n = 0;
    while (dack !== 1'b1 && n < 10) begin tick(); n++; end
    base_addr = 10'd0; xfer_len = 10'd7; dir_up = 0; start = 1;
    n = 0;
    while (busy === 1'b1 && n < 20) begin tick(); n++; end
    start = 0;
    checks++;
    if (dack_n != 3 || done_n != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_start got=%0d/%0d/%0d exp=3/1/0",
        dack_n, done_n, exp_q.size());
    end
    checks++;
    if (cnt_data !== 10'd200 || cnt_dir !== 1) begin
      errors++;
      $display("FAIL ignore_latch got=%0d/%b exp=200/1",
        cnt_data, cnt_dir);
    end
  endtask

  task automatic test_mr_mid_xfer();
    int n;
    clear_stats();
    base_addr = 10'd300; xfer_len = 10'd4; dir_up = 1;
    dreq = 1; start = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back(10'(300 + i));
    tick();
    start = 0;
    n = 0;
    while (!(dack === 1'b1 && remaining === 10'd2) && n < 20) begin
      tick(); n++;
    end
    checks++;
    if (dack !== 1 || remaining !== 10'd2) begin
      errors++;
      $display("FAIL mr_setup got=%b/%0d exp=1/2", dack, remaining);
    end
    MR = 1;
    tick();
    MR = 0;
    checks++;
    if ({cnt_data, cnt_load, cnt_en, cnt_dir, dack,
         busy, done, err, remaining} !== '0) begin
      errors++;
      $display("FAIL mr_outputs got=%h exp=0",
        {cnt_data, cnt_load, cnt_en, cnt_dir, dack,
         busy, done, err, remaining});
    end
    checks++;
    if (dack_n != 3 || done_n != 0) begin
      errors++;
      $display("FAIL mr_counts got=%0d/%0d exp=3/0", dack_n, done_n);
    end
    exp_q.delete();
    dreq = 0;
    tick();
  endtask

`ifdef DMA_AUTOINIT_EN
  task automatic test_autoinit();
    int n;
    clear_stats();
    base_addr = 10'd400; xfer_len = 10'd2; dir_up = 1;
    dreq = 1; start = 1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(10'd400);
      exp_q.push_back(10'd401);
    end
    tick();
    start = 0;
    n = 0;
    while (done_hist.size() < 3 && n < 40) begin tick(); n++; end
    checks++;
    if (done_hist.size() < 3) begin
      errors++;
      $display("FAIL auto_timeout got=%0d exp=3", done_hist.size());
    end else begin
      checks++;
      if (done_hist[1] - done_hist[0] != 5 ||
          done_hist[2] - done_hist[1] != 5) begin
        errors++;
        $display("FAIL auto_period got=%0d,%0d exp=5,5",
          done_hist[1] - done_hist[0], done_hist[2] - done_hist[1]);
      end
    end
    checks++;
    if (busy !== 1) begin
      errors++;
      $display("FAIL auto_busy got=%b exp=1", busy);
    end
    MR = 1;
    tick();
    MR = 0;
    exp_q.delete();
    dreq = 0;
    checks++;
    if (busy !== 0 || remaining !== 0) begin
      errors++;
      $display("FAIL auto_mr got=%b/%0d exp=0/0", busy, remaining);
    end
    tick();
  endtask
`endif

  initial begin
    prev_dreq = 0;
    test_reset();
    test_basic_up();
    test_toggle_down();
    test_wrap_err();
    test_zero_len();
    test_start_ignored();
    test_mr_mid_xfer();
`ifdef DMA_AUTOINIT_EN
    test_autoinit();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
